// File: rtl/subckt_eval_scheduler_if.sv
// ----------------------------------------------------------------------------
// subckt_eval_scheduler_if : request, DUT-drive and response bundle
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface subckt_eval_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int IN_W    = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*IN_W-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic [IN_W-1:0]         dut_in;
  logic                    dut_rst;
  logic                    dut_out;
  logic                    resp_valid;
  logic [ID_W-1:0]         resp_id;
  logic                    resp_data;
  logic                    resp_ready;

  // Environment side: requesters, the netlist under test and the result consumer.
  modport master (
    output req_valid, req_data, dut_out, resp_ready,
    input  req_ready, dut_in, dut_rst, resp_valid, resp_id, resp_data
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_data, dut_out, resp_ready,
    output req_ready, dut_in, dut_rst, resp_valid, resp_id, resp_data
  );
endinterface

`default_nettype wire

// File: rtl/subckt_eval_scheduler.sv
// ----------------------------------------------------------------------------
// subckt_eval_scheduler : round-robin time-sharing of one clocked netlist
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module subckt_eval_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int IN_W         = 2,
  parameter int LATENCY      = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                  I1470_clk,
  input  logic                  I1477_rst,
  subckt_eval_scheduler_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    APPLY = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] id;
  logic [IN_W-1:0] vec;
  logic [2:0]      flush_cnt;
  logic [3:0]      apply_cnt;

  logic [ID_W-1:0]    cand;
  logic [ID_W-1:0]    grant_id;
  logic               grant_any;
  logic [NUM_REQ-1:0] grant;
  logic [IN_W-1:0]    grant_vec;

  // Search starts just after the last winner so every requester is served in turn.
  always_comb begin
    cand      = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    grant     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_any && bus.req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
    if (state == IDLE && !I1477_rst && grant_any) begin
      grant[grant_id] = 1'b1;
    end
    grant_vec = bus.req_data[grant_id*IN_W +: IN_W];
  end

  assign bus.req_ready = grant;

  always_ff @(posedge I1470_clk) begin
    if (I1477_rst) begin
      state          <= IDLE;
      rr_ptr         <= ID_W'(NUM_REQ - 1);
      id             <= '0;
      vec            <= '0;
      flush_cnt      <= '0;
      apply_cnt      <= '0;
      bus.dut_in     <= '0;
      bus.dut_rst    <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_id    <= '0;
      bus.resp_data  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.dut_rst <= 1'b0;
          bus.dut_in  <= '0;
          if (|grant) begin
            id          <= grant_id;
            rr_ptr      <= grant_id;
            vec         <= grant_vec;
            bus.dut_in  <= grant_vec;
            bus.dut_rst <= 1'b1;
            flush_cnt   <= 3'(FLUSH_CYCLES - 1);
            state       <= FLUSH;
          end
        end
        FLUSH: begin
          if (flush_cnt == 3'd0) begin
            bus.dut_rst <= 1'b0;
            apply_cnt   <= 4'(LATENCY - 1);
            state       <= APPLY;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        APPLY: begin
          // Capture on the edge that closes the last stimulus cycle.
          if (apply_cnt == 4'd0) begin
            bus.resp_data  <= bus.dut_out;
            bus.resp_id    <= id;
            bus.resp_valid <= 1'b1;
            bus.dut_in     <= '0;
            state          <= RESP;
          end else begin
            apply_cnt <= apply_cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_vec;
  assign unused_vec = ^vec;
endmodule

`default_nettype wire

// File: tb/tb_subckt_eval_scheduler.sv
// ----------------------------------------------------------------------------
// tb_subckt_eval_scheduler : directed and random bench with a scoreboard model
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_subckt_eval_scheduler;
  localparam int NUM_REQ = 4;
  localparam int IN_W    = 2;
  localparam int LAT     = 2;
  localparam int FL      = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  subckt_eval_scheduler_if #(.NUM_REQ(NUM_REQ), .IN_W(IN_W)) bus ();
  subckt_eval_scheduler_if #(.NUM_REQ(NUM_REQ), .IN_W(IN_W)) bus2 ();

  subckt_eval_scheduler #(.NUM_REQ(NUM_REQ), .IN_W(IN_W), .LATENCY(LAT), .FLUSH_CYCLES(FL)) dut (
    .I1470_clk(clk), .I1477_rst(rst), .bus(bus));

  subckt_eval_scheduler #(.NUM_REQ(NUM_REQ), .IN_W(IN_W), .LATENCY(4), .FLUSH_CYCLES(3)) dut2 (
    .I1470_clk(clk), .I1477_rst(rst), .bus(bus2));

  // Stand-in netlists: registered parity of the stimulus, cleared while dut_rst is high.
  logic par1 = 1'b0;
  logic par2 = 1'b0;
  always @(posedge clk) begin
    par1 <= bus.dut_rst  ? 1'b0 : ^bus.dut_in;
    par2 <= bus2.dut_rst ? 1'b0 : ^bus2.dut_in;
  end
  assign bus.dut_out  = par1;
  assign bus2.dut_out = par2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int last = NUM_REQ - 1;
  int last_acc = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbiter: first valid requester after the previous winner, cyclically.
  function automatic int model_pick(input logic [NUM_REQ-1:0] v);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid  = '0;
    bus2.req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last = NUM_REQ - 1;
    last_acc = -1;
  endtask

  // One full evaluation on the default instance; called and returning at a negedge.
  task automatic eval_one(input string tag, input logic [3:0] v, input logic [7:0] d,
                          input int hold, output int gid);
    int exp_id, lows, rsts, t;
    logic [1:0] vec;
    logic ok_in, ok_rdy, ok_hold;
    gid = -1;
    bus.req_valid  = v;
    bus.req_data   = d;
    bus.resp_ready = (hold == 0);
    exp_id = model_pick(v);
    #1;
    t = 0;
    while (bus.req_ready == '0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " grant"}, 32'(bus.req_ready), 32'(1) << exp_id);
    for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) gid = i;
    if (last_acc >= 0) chk({tag, " gap>=5"}, 32'(cyc + 1 - last_acc >= 5), 32'd1);
    last_acc = cyc + 1;
    last = exp_id;
    vec = d[exp_id*2 +: 2];
    @(posedge clk);
    #1 bus.req_data = ~d;
    lows = 0; rsts = 0; ok_in = 1'b1; ok_rdy = 1'b1;
    @(negedge clk);
    while (!bus.resp_valid && lows < 40) begin
      lows++;
      if (bus.dut_rst) rsts++;
      if (bus.dut_in !== vec) ok_in = 1'b0;
      if (bus.req_ready !== '0) ok_rdy = 1'b0;
      @(negedge clk);
    end
    chk({tag, " latency"}, 32'(lows), 32'(FL + LAT));
    chk({tag, " flush cycles"}, 32'(rsts), 32'(FL));
    chk({tag, " dut_in held"}, 32'(ok_in), 32'd1);
    chk({tag, " ready low busy"}, 32'(ok_rdy), 32'd1);
    chk({tag, " resp_id"}, 32'(bus.resp_id), 32'(exp_id));
    chk({tag, " resp_data"}, 32'(bus.resp_data), 32'(^vec));
    if (hold > 0) begin
      ok_hold = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'(exp_id) ||
            bus.resp_data !== ^vec || bus.req_ready !== '0) ok_hold = 1'b0;
      end
      chk({tag, " backpressure stable"}, 32'(ok_hold), 32'd1);
      bus.resp_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, " resp_valid drop"}, 32'(bus.resp_valid), 32'd0);
    if (hold > 0) chk({tag, " regrant next cycle"}, 32'(bus.req_ready != '0), 32'd1);
  endtask

  initial begin
    int gid, t, lows, rsts;
    int cnt [NUM_REQ];
    logic ok;
    logic [3:0] rv;
    logic [7:0] rd;
    int rh;
    int exp_fair [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_cont [4] = '{0, 2, 0, 2};

    bus.req_valid = 4'b1111; bus.req_data = '0; bus.resp_ready = 1'b0;
    bus2.req_valid = '0; bus2.req_data = '0; bus2.resp_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset dut_rst", 32'(bus.dut_rst), 32'd1);
    chk("reset dut_in", 32'(bus.dut_in), 32'd0);
    chk("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("reset resp_id", 32'(bus.resp_id), 32'd0);
    chk("reset resp_data", 32'(bus.resp_data), 32'd0);
    bus.req_valid = '0;
    rst = 1'b0;

    eval_one("single", 4'b0001, 8'b0000_0001, 0, gid);
    chk("single id", 32'(gid), 32'd0);
    bus.req_valid = '0;

    do_reset();
    for (int n = 0; n < 4; n++) begin
      eval_one("contend", 4'b0101, 8'($urandom), 0, gid);
      chk("contend order", 32'(gid), 32'(exp_cont[n]));
    end
    bus.req_valid = '0;

    do_reset();
    for (int i = 0; i < NUM_REQ; i++) cnt[i] = 0;
    for (int n = 0; n < 8; n++) begin
      eval_one("fair", 4'b1111, 8'($urandom), 0, gid);
      chk("fair order", 32'(gid), 32'(exp_fair[n]));
      if (gid >= 0) cnt[gid]++;
    end
    for (int i = 0; i < NUM_REQ; i++) chk("fair share", 32'(cnt[i]), 32'd2);
    bus.req_valid = '0;

    eval_one("backpressure", 4'b0110, 8'b0010_1100, 10, gid);
    eval_one("after release", 4'b0110, 8'b0001_0100, 0, gid);
    bus.req_valid = '0;

    // Abort in APPLY: reset for one cycle and expect no response for the request.
    do_reset();
    bus.req_valid = 4'b0100; bus.req_data = 8'h30; bus.resp_ready = 1'b1;
    #1;
    t = 0;
    while (bus.req_ready == '0 && t < 20) begin @(negedge clk); t++; end
    chk("abort grant", 32'(bus.req_ready), 32'b0100);
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort dut_rst", 32'(bus.dut_rst), 32'd1);
    chk("abort resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("abort dut_in", 32'(bus.dut_in), 32'd0);
    rst = 1'b0;
    last = NUM_REQ - 1;
    last_acc = -1;
    ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0) ok = 1'b0;
    end
    chk("abort no response", 32'(ok), 32'd1);
    eval_one("post-abort", 4'b1111, 8'($urandom), 0, gid);
    chk("post-abort id", 32'(gid), 32'd0);
    bus.req_valid = '0;

    for (int n = 0; n < 24; n++) begin
      rv = 4'($urandom_range(1, 15));
      rd = 8'($urandom);
      rh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      eval_one("random", rv, rd, rh, gid);
    end
    bus.req_valid = '0;

    // Longer pipeline instance: FLUSH_CYCLES=3, LATENCY=4.
    bus2.req_valid = 4'b0010; bus2.req_data = 8'b0000_1000; bus2.resp_ready = 1'b1;
    #1;
    t = 0;
    while (bus2.req_ready == '0 && t < 20) begin @(negedge clk); t++; end
    chk("sweep grant", 32'(bus2.req_ready), 32'b0010);
    @(posedge clk);
    #1 bus2.req_valid = '0;
    lows = 0; rsts = 0; ok = 1'b1;
    @(negedge clk);
    while (!bus2.resp_valid && lows < 60) begin
      lows++;
      if (bus2.dut_rst) rsts++;
      if (bus2.dut_in !== 2'b10) ok = 1'b0;
      @(negedge clk);
    end
    chk("sweep latency", 32'(lows), 32'd7);
    chk("sweep flush cycles", 32'(rsts), 32'd3);
    chk("sweep dut_in held", 32'(ok), 32'd1);
    chk("sweep resp_id", 32'(bus2.resp_id), 32'd1);
    chk("sweep resp_data", 32'(bus2.resp_data), 32'd1);
    @(negedge clk);
    chk("sweep resp_valid drop", 32'(bus2.resp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

`default_nettype wire
